// File: rtl/node_rx_module_if.sv
// rtl/node_rx_module_if.sv - router ejection, credit return and PE delivery signals of the node receive endpoint
interface node_rx_module_if #(
  parameter int VC_BITS = 1
);
  logic [72:0]        i_flit;
  logic               o_credit_valid;
  logic [VC_BITS-1:0] o_credit;
  logic               o_req_rx;
  logic [7:0]         o_rx_src;
  logic               i_ack_rx;
  logic [31:0]        o_data;
  logic               o_data_valid;
  logic               o_data_last;
  logic               i_data_ready;

  modport slave (
    input  i_flit, i_ack_rx, i_data_ready,
    output o_credit_valid, o_credit, o_req_rx, o_rx_src,
           o_data, o_data_valid, o_data_last
  );

  modport master (
    output i_flit, i_ack_rx, i_data_ready,
    input  o_credit_valid, o_credit, o_req_rx, o_rx_src,
           o_data, o_data_valid, o_data_last
  );
endinterface

// File: rtl/node_rx_module.sv
// rtl/node_rx_module.sv - node receive endpoint: buffers ejected flits, returns credits, hands packets to the PE
module node_rx_module #(
  parameter int DEPTH   = 4,
  parameter int VC_BITS = 1,
  parameter int CNT_W   = 8
) (
  input  logic             N_clk,
  input  logic             N_rst,
  input  logic [7:0]       local_id,
  node_rx_module_if.slave  rx,
  output logic [CNT_W-1:0] o_misroute_cnt,
  output logic             o_overflow
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int KW = $clog2(DEPTH + 2);
  localparam logic [PW-1:0] LAST_IDX = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, STREAM} state_t;
  state_t state, state_nxt;

  // entry layout: {tail, src, payload}
  logic [40:0]   mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, pkt_cnt;
  logic [KW-1:0] cred_cnt;

  logic        flit_vld, flit_tail, dst_hit, empty;
  logic        pop, wr_en, drop_mis, drop_full, head_tail;
  logic [40:0] head;
  logic        unused_flit;

  assign flit_vld    = rx.i_flit[72];
  assign flit_tail   = rx.i_flit[71];
  assign dst_hit     = (rx.i_flit[70:63] == local_id);
  assign unused_flit = ^rx.i_flit[62:40];

  assign head      = mem[rd_ptr];
  assign head_tail = head[40];
  assign empty     = (count == '0);
  assign pop       = (state == STREAM) && !empty && rx.i_data_ready;

  // a pop in the same cycle frees the slot the incoming flit needs
  assign wr_en     = flit_vld && dst_hit && ((count != FULL_CNT) || pop);
  assign drop_full = flit_vld && dst_hit && (count == FULL_CNT) && !pop;
  assign drop_mis  = flit_vld && !dst_hit;

  always_ff @(posedge N_clk) begin
    if (wr_en) mem[wr_ptr] <= {flit_tail, rx.i_flit[39:32], rx.i_flit[31:0]};
  end

  always_ff @(posedge N_clk or negedge N_rst) begin
    if (!N_rst) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      pkt_cnt        <= '0;
      cred_cnt       <= '0;
      o_misroute_cnt <= '0;
      o_overflow     <= 1'b0;
      state          <= IDLE;
    end else begin
      state <= state_nxt;
      if (wr_en) wr_ptr <= (wr_ptr == LAST_IDX) ? '0 : wr_ptr + 1'b1;
      if (pop)   rd_ptr <= (rd_ptr == LAST_IDX) ? '0 : rd_ptr + 1'b1;
      count    <= count + CW'(wr_en) - CW'(pop);
      pkt_cnt  <= pkt_cnt + CW'(wr_en && flit_tail) - CW'(pop && head_tail);
      cred_cnt <= cred_cnt + KW'(pop) + KW'(drop_mis) - KW'(cred_cnt != '0);
      if (drop_mis && (o_misroute_cnt != '1)) o_misroute_cnt <= o_misroute_cnt + 1'b1;
      if (drop_full) o_overflow <= 1'b1;
    end
  end

  assign rx.o_credit_valid = (cred_cnt != '0);
  assign rx.o_credit       = '0;

  always_comb begin
    state_nxt       = state;
    rx.o_req_rx     = 1'b0;
    rx.o_rx_src     = '0;
    rx.o_data_valid = 1'b0;
    rx.o_data       = '0;
    rx.o_data_last  = 1'b0;
    case (state)
      IDLE: begin
        if (pkt_cnt != '0) state_nxt = REQ;
      end
      REQ: begin
        rx.o_req_rx = 1'b1;
        rx.o_rx_src = head[39:32];
        if (rx.i_ack_rx) state_nxt = STREAM;
      end
      STREAM: begin
        rx.o_data_valid = !empty;
        if (!empty) begin
          rx.o_data      = head[31:0];
          rx.o_data_last = head_tail;
        end
        if (pop && head_tail) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_node_rx_module.sv
// tb/tb_node_rx_module.sv - self-checking bench for node_rx_module
module tb_node_rx_module;
  localparam int DEPTH = 4;

  logic       N_clk = 1'b0;
  logic       N_rst = 1'b0;
  logic [7:0] local_id;
  logic [7:0] mis_cnt;
  logic       ovf;

  node_rx_module_if #(.VC_BITS(1)) rx();

  node_rx_module #(.DEPTH(DEPTH), .VC_BITS(1), .CNT_W(8)) dut (
    .N_clk(N_clk),
    .N_rst(N_rst),
    .local_id(local_id),
    .rx(rx),
    .o_misroute_cnt(mis_cnt),
    .o_overflow(ovf)
  );

  always #5 N_clk = ~N_clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int rc = 0;
  int viol = 0;
  bit rand_on = 1'b0;
  logic [32:0] words[$];
  int          pop_cyc[$];
  int          cred_cyc[$];
  logic [7:0]  srcs[$];

  typedef struct {
    logic [7:0]  dst;
    logic [7:0]  src;
    logic [31:0] pl;
    int          deliver;
    int          exp_mis;
  } vec_t;
  vec_t tbl[6];

  always @(posedge N_clk) cyc <= cyc + 1;

  // observer: words accepted, credit pulses, offered sources
  always @(negedge N_clk) begin
    if (N_rst) begin
      if (rx.o_data_valid && rx.i_data_ready) begin
        words.push_back({rx.o_data_last, rx.o_data});
        pop_cyc.push_back(cyc);
      end
      if (rx.o_credit_valid) begin
        cred_cyc.push_back(cyc);
        rc++;
      end
      if (rx.o_req_rx && rx.i_ack_rx) srcs.push_back(rx.o_rx_src);
      if (rx.o_req_rx && rx.o_data_valid) viol++;
    end
  end

  always @(posedge N_clk) begin
    if (rand_on) begin
      #1;
      rx.i_data_ready = ($urandom_range(0, 3) != 0);
      rx.i_ack_rx     = ($urandom_range(0, 2) == 0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge N_clk);
    #1;
  endtask

  function automatic logic [72:0] mk(input logic tail, input logic [7:0] dst,
                                     input logic [7:0] src, input logic [31:0] pl);
    logic [72:0] f;
    f = '0;
    f[72] = 1'b1;
    f[71] = tail;
    f[70:63] = dst;
    f[39:32] = src;
    f[31:0] = pl;
    return f;
  endfunction

  task automatic send(input logic [7:0] dst, input logic [7:0] src, input logic [31:0] pl, input logic tail);
    rx.i_flit = mk(tail, dst, src, pl);
    tick();
  endtask

  task automatic idle(input int n);
    rx.i_flit = '0;
    repeat (n) tick();
  endtask

  task automatic do_reset();
    rx.i_flit = '0;
    N_rst = 1'b0;
    tick();
    tick();
    N_rst = 1'b1;
    tick();
  endtask

  task automatic clrq();
    words.delete();
    pop_cyc.delete();
    cred_cyc.delete();
    srcs.delete();
  endtask

  initial begin
    logic [32:0] exp_w[$];
    logic [7:0]  exp_s[$];
    int exp_mis, tmo, n, werr, serr, len;
    bit hit;
    logic [7:0]  dst, src;
    logic [31:0] pl;

    tbl[0] = '{8'd4,   8'd1,   32'h11111111, 1, 0};
    tbl[1] = '{8'd0,   8'd2,   32'h00000022, 0, 1};
    tbl[2] = '{8'd255, 8'd3,   32'h00000033, 0, 2};
    tbl[3] = '{8'd4,   8'd255, 32'hFFFFFFFF, 1, 2};
    tbl[4] = '{8'd5,   8'd4,   32'h00000055, 0, 3};
    tbl[5] = '{8'd4,   8'd0,   32'h00000000, 1, 3};

    rx.i_flit = '0;
    rx.i_ack_rx = 1'b0;
    rx.i_data_ready = 1'b0;
    local_id = 8'd4;
    N_rst = 1'b0;
    #12;
    check("rst_flags", {rx.o_req_rx, rx.o_data_valid, rx.o_data_last, rx.o_credit_valid, rx.o_credit, ovf}, 64'd0);
    check("rst_data", rx.o_data, 64'd0);
    check("rst_src", rx.o_rx_src, 64'd0);
    check("rst_mis", mis_cnt, 64'd0);
    tick();
    N_rst = 1'b1;
    tick();

    // two-flit packet, free-running handshake
    rx.i_ack_rx = 1'b1;
    rx.i_data_ready = 1'b1;
    clrq();
    send(8'd4, 8'd7, 32'h40200000, 1'b0);
    send(8'd4, 8'd7, 32'hFFFFFFFF, 1'b1);
    idle(10);
    check("t1_nsrc", srcs.size(), 64'd1);
    if (srcs.size() == 1) check("t1_src", srcs[0], 64'd7);
    check("t1_nwords", words.size(), 64'd2);
    if (words.size() == 2) begin
      check("t1_w0", words[0], {1'b0, 32'h40200000});
      check("t1_w1", words[1], {1'b1, 32'hFFFFFFFF});
    end
    check("t1_ncred", cred_cyc.size(), 64'd2);
    if (cred_cyc.size() == 2 && pop_cyc.size() == 2)
      for (int i = 0; i < 2; i++) check("t1_cred_lat", cred_cyc[i], 64'(pop_cyc[i] + 1));

    // single-flit vectors, hit and miss
    for (int i = 0; i < 6; i++) begin
      clrq();
      send(tbl[i].dst, tbl[i].src, tbl[i].pl, 1'b1);
      idle(8);
      check("tv_nwords", words.size(), 64'(tbl[i].deliver));
      if (tbl[i].deliver == 1 && words.size() == 1 && srcs.size() == 1) begin
        check("tv_word", words[0], {1'b1, tbl[i].pl});
        check("tv_src", srcs[0], tbl[i].src);
      end
      check("tv_mis", mis_cnt, 64'(tbl[i].exp_mis));
      check("tv_ncred", cred_cyc.size(), 64'd1);
    end

    // misroute counting and saturation
    do_reset();
    clrq();
    send(8'd5, 8'd1, 32'hDEAD, 1'b1);
    idle(5);
    check("t2_nwords", words.size(), 64'd0);
    check("t2_mis1", mis_cnt, 64'd1);
    check("t2_ncred1", cred_cyc.size(), 64'd1);
    clrq();
    for (int i = 0; i < 300; i++) send(8'd5, 8'd1, 32'(i), 1'b1);
    idle(5);
    check("t2_mis_sat", mis_cnt, 64'd255);
    check("t2_ncred300", cred_cyc.size(), 64'd300);

    // overflow with the PE stalled
    do_reset();
    rx.i_data_ready = 1'b0;
    rx.i_ack_rx = 1'b1;
    clrq();
    for (int i = 0; i < 5; i++) send(8'd4, 8'd2, 32'h100 + 32'(i), 1'b1);
    idle(6);
    check("t3_ovf", ovf, 64'd1);
    check("t3_nwords0", words.size(), 64'd0);
    check("t3_ncred0", cred_cyc.size(), 64'd0);
    rx.i_data_ready = 1'b1;
    idle(30);
    check("t3_nwords", words.size(), 64'd4);
    if (words.size() == 4)
      for (int i = 0; i < 4; i++) check("t3_word", words[i], {1'b1, 32'h100 + 32'(i)});
    check("t3_ncred", cred_cyc.size(), 64'd4);
    check("t3_ovf_sticky", ovf, 64'd1);

    // pop and misroute in the same cycle
    do_reset();
    rx.i_data_ready = 1'b0;
    rx.i_ack_rx = 1'b1;
    send(8'd4, 8'd3, 32'hAA, 1'b1);
    idle(5);
    check("t4_valid", rx.o_data_valid, 64'd1);
    clrq();
    rx.i_data_ready = 1'b1;
    send(8'd5, 8'd3, 32'hBB, 1'b1);
    idle(5);
    check("t4_npop", pop_cyc.size(), 64'd1);
    check("t4_ncred", cred_cyc.size(), 64'd2);
    if (pop_cyc.size() == 1 && cred_cyc.size() == 2) begin
      check("t4_cred0", cred_cyc[0], 64'(pop_cyc[0] + 1));
      check("t4_cred1", cred_cyc[1], 64'(pop_cyc[0] + 2));
    end

    // back-to-back packets with a delayed ack on the second
    do_reset();
    rx.i_ack_rx = 1'b0;
    rx.i_data_ready = 1'b1;
    clrq();
    for (int i = 0; i < 3; i++) send(8'd4, 8'(11 + i), 32'h500 + 32'(i), 1'b1);
    idle(0);
    for (int p = 0; p < 3; p++) begin
      n = 0;
      while (!rx.o_req_rx && n < 20) begin
        tick();
        n++;
      end
      check("t5_req", rx.o_req_rx, 64'd1);
      check("t5_src", rx.o_rx_src, 64'(11 + p));
      for (int h = 0; h < ((p == 1) ? 3 : 0); h++) begin
        tick();
        check("t5_hold", {rx.o_req_rx, rx.o_data_valid, rx.o_rx_src}, {1'b1, 1'b0, 8'(11 + p)});
      end
      rx.i_ack_rx = 1'b1;
      tick();
      rx.i_ack_rx = 1'b0;
      check("t5_word", {rx.o_data_valid, rx.o_data_last, rx.o_data}, {1'b1, 1'b1, 32'h500 + 32'(p)});
      tick();
    end
    idle(4);
    check("t5_nwords", words.size(), 64'd3);

    // asynchronous reset in the middle of a stream
    do_reset();
    rx.i_ack_rx = 1'b1;
    rx.i_data_ready = 1'b0;
    send(8'd4, 8'd9, 32'h600, 1'b0);
    send(8'd4, 8'd9, 32'h601, 1'b1);
    idle(5);
    check("t6_pre_valid", rx.o_data_valid, 64'd1);
    #2;
    N_rst = 1'b0;
    #1;
    check("t6_rst_flags", {rx.o_req_rx, rx.o_data_valid, rx.o_data_last, rx.o_credit_valid, ovf}, 64'd0);
    check("t6_rst_data", rx.o_data, 64'd0);
    tick();
    N_rst = 1'b1;
    rx.i_data_ready = 1'b1;
    clrq();
    send(8'd4, 8'd8, 32'h700, 1'b0);
    send(8'd4, 8'd8, 32'h701, 1'b1);
    idle(10);
    check("t6_nwords", words.size(), 64'd2);
    if (words.size() == 2) begin
      check("t6_w0", words[0], {1'b0, 32'h700});
      check("t6_w1", words[1], {1'b1, 32'h701});
    end
    if (srcs.size() == 1) check("t6_src", srcs[0], 64'd8);
    check("t6_ncred", cred_cyc.size(), 64'd2);

    // randomized traffic under credit flow control against a packet-level model
    do_reset();
    local_id = 8'h3C;
    tick();
    rc = DEPTH;
    viol = 0;
    clrq();
    exp_mis = 0;
    tmo = 0;
    rand_on = 1'b1;
    for (int pk = 0; pk < 40; pk++) begin
      len = $urandom_range(1, 4);
      hit = ($urandom_range(0, 3) != 0);
      dst = hit ? local_id : (local_id ^ 8'($urandom_range(1, 255)));
      src = 8'($urandom);
      if (hit) exp_s.push_back(src);
      for (int f = 0; f < len; f++) begin
        pl = $urandom;
        n = 0;
        while (rc == 0 && n < 500) begin
          rx.i_flit = '0;
          tick();
          n++;
        end
        if (rc == 0) tmo++;
        rx.i_flit = mk(f == len - 1, dst, src, pl);
        rc--;
        tick();
        if (hit) exp_w.push_back({(f == len - 1), pl});
        else exp_mis++;
        if ($urandom_range(0, 3) == 0) idle(1);
      end
    end
    rx.i_flit = '0;
    n = 0;
    while ((words.size() < exp_w.size() || rc != DEPTH) && n < 3000) begin
      tick();
      n++;
    end
    rand_on = 1'b0;
    idle(3);
    check("rnd_credit_wait", tmo, 64'd0);
    check("rnd_nwords", words.size(), 64'(exp_w.size()));
    werr = 0;
    if (words.size() == exp_w.size())
      for (int i = 0; i < exp_w.size(); i++) if (words[i] !== exp_w[i]) werr++;
    check("rnd_words", werr, 64'd0);
    check("rnd_nsrc", srcs.size(), 64'(exp_s.size()));
    serr = 0;
    if (srcs.size() == exp_s.size())
      for (int i = 0; i < exp_s.size(); i++) if (srcs[i] !== exp_s[i]) serr++;
    check("rnd_srcs", serr, 64'd0);
    check("rnd_mis", mis_cnt, 64'((exp_mis > 255) ? 255 : exp_mis));
    check("rnd_credits_home", rc, 64'(DEPTH));
    check("rnd_no_ovf", ovf, 64'd0);
    check("rnd_req_vs_data", viol, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/node_rx_module.md
Name: node_rx_module

Overview:
- Receive-side endpoint of the node↔router link. It is the counterpart of the PE-to-IF send path.
- Accepts 73-bit flits ejected by the router and buffers them in a local FIFO. It returns flow-control credits to the router.
- Presents each complete packet to the PE through a req/ack handshake, then streams the packet as 32-bit words with valid/ready.

Parameters:
- DEPTH, 4, FIFO depth in flits. The router's initial credit count for this port equals DEPTH.
- VC_BITS, 1, width of the flit VC field and of o_credit.
- CNT_W, 8, width of the saturating misroute counter.

Ports:
- N_clk  input  1  clock
- N_rst  input  1  reset, asynchronous, active-low
- local_id  input  8  node id; must be held stable while out of reset
- i_flit  input  73  ejected flit. [72] valid, [71] tail, [70:63] dst, [62 -: VC_BITS] vc, [39:32] src, [31:0] payload
- o_credit_valid  output  1  one-cycle pulse; returns one credit
- o_credit  output  VC_BITS  VC of returned credit (always 0)
- o_req_rx  output  1  at least one complete packet is buffered
- o_rx_src  output  8  src field of the head flit; valid while o_req_rx=1
- i_ack_rx  input  1  PE accepts the offered packet
- o_data  output  32  payload word
- o_data_valid  output  1  word valid
- o_data_last  output  1  word is the tail flit
- i_data_ready  input  1  PE consumes the word
- o_misroute_cnt  output  CNT_W  saturating count of flits with dst≠local_id
- o_overflow  output  1  sticky; a valid flit arrived while the FIFO was full

Behaviour:
- Reset (async, N_rst=0):
  - All outputs 0.
  - FIFO empty, pointers 0, packet count 0, pending-credit count 0.
  - FSM in IDLE.
- Ingress (i_flit[72]=1), evaluated at posedge:
  - dst==local_id and FIFO not full: write the flit. If the tail bit is set, increment pkt_cnt.
  - dst≠local_id: drop the flit, increment o_misroute_cnt (saturates at all-ones), and increment the pending-credit count.
  - FIFO full with matching dst: drop the flit, set o_overflow, no credit. Checked after the same-cycle pop, so a simultaneous pop frees the slot and the write succeeds.
- Credits:
  - Each FIFO pop and each misroute drop adds 1 to the pending-credit count.
  - Whenever the count is >0, o_credit_valid=1 for that cycle and the count decrements.
  - At most one credit per cycle. A pop and a drop in the same cycle yield two pulses on consecutive cycles.
  - Registered: the first pulse comes 1 cycle after the causing event.
  - The count never exceeds DEPTH+1.
- FSM IDLE → REQ → STREAM → IDLE:
  - IDLE: when pkt_cnt>0, go to REQ.
  - REQ: o_req_rx=1 and o_rx_src=head.src. When i_ack_rx=1, go to STREAM. i_ack_rx is ignored in other states.
  - STREAM: o_data_valid=1 whenever the FIFO is non-empty; o_data is the head payload and o_data_last is the head tail bit.
    - Pop on valid&&ready.
    - Popping a tail decrements pkt_cnt and returns to IDLE.
    - A decrement and a same-cycle tail write leave pkt_cnt unchanged.
  - Back-to-back packets: IDLE→REQ costs one cycle. Minimum 2 idle data cycles between packets.
  - o_data_valid may deassert mid-packet if the body flits have not yet arrived. It is never asserted outside STREAM.
- Outputs: o_req_rx, o_rx_src, o_data, o_data_valid and o_data_last are combinational from the FSM state and FIFO head.
- Single-flit packet: head with tail=1; delivered as one word with o_data_last=1.
- Mid-operation reset: discards the FIFO and pending credits. The router side must be reset concurrently.
- Pointers wrap modulo DEPTH. A DEPTH that is not a power of two is supported via explicit wrap compares.

Test Plan:
- Reset, local_id=4. Inject a 2-flit packet (dst=4, src=7, payloads 0x40200000, 0xFFFFFFFF; tail on the 2nd flit) with i_ack_rx and i_data_ready held high. Required:
  - o_req_rx with o_rx_src=7.
  - Words delivered in order; o_data_last only on the 2nd.
  - Exactly 2 credit pulses, each 1 cycle after its pop.
- Flit with dst=5 at local_id=4: not delivered, o_misroute_cnt=1, one credit pulse. Inject 300 misroutes: counter stays at 255.
- i_data_ready=0, inject 5 matching flits with DEPTH=4: first 4 buffered, 5th dropped, o_overflow=1, 4 credits after draining. o_overflow stays 1 until reset.
- Pop a word and receive a misrouted flit in the same cycle: o_credit_valid high on 2 consecutive cycles.
- Deliver three single-flit packets back-to-back; hold i_ack_rx low for 3 cycles on the 2nd: o_req_rx and o_rx_src held stable, no data words during the wait, order preserved.
- Assert N_rst low mid-STREAM between clock edges: outputs clear immediately, and the next packet is delivered correctly.
